// File: rtl/muxn_pipe.sv
// muxn_pipe: registered N-to-1 channel select with a two-entry (head + skid)
// valid/ready pipeline stage.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   d          N concatenated channels, channel i at [i*WIDTH +: WIDTH]
//   sel        channel index captured with each accepted beat
//   in_valid   upstream offers a beat
//   in_ready   block can accept a beat this cycle (registered)
//   out_valid  y/sel_err hold a beat (registered)
//   out_ready  downstream accepts the head beat
//   flush      synchronous discard of all held beats
//   y          selected data of the head beat
//   sel_err    head beat's select was out of range or unknown
module muxn_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   y,
  output logic               sel_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   head_data_q, head_data_d;
  logic               head_err_q, head_err_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic               skid_err_q, skid_err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic               deliver;
  logic [WIDTH-1:0]   cap_data;
  logic               cap_err;

  assign accept  = in_valid && in_ready_q;
  assign deliver = out_valid_q && out_ready;

  // Channel select; any select that matches no channel (out of range, or
  // carrying X/Z bits) falls back to channel 0 and flags the error.
  always_comb begin
    cap_err  = 1'b1;
    cap_data = d[WIDTH-1:0];
    for (int i = 0; i < int'(N); i++) begin
      if (sel == SELW'(i)) begin
        cap_err  = 1'b0;
        cap_data = d[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register and all datapath/output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_err_q  <= head_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic; flush overrides any accept/deliver.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (accept) state_d = S_ONE;
      S_ONE: begin
        if (accept && !deliver)      state_d = S_FULL;
        else if (!accept && deliver) state_d = S_EMPTY;
      end
      S_FULL:  if (deliver) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  // Datapath moves and next values of the registered handshake outputs.
  always_comb begin
    head_data_d = head_data_q;
    head_err_d  = head_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    if (!flush) begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            head_data_d = cap_data;
            head_err_d  = cap_err;
          end
        end
        S_ONE: begin
          if (accept && deliver) begin
            head_data_d = cap_data;
            head_err_d  = cap_err;
          end else if (accept) begin
            skid_data_d = cap_data;
            skid_err_d  = cap_err;
          end
        end
        S_FULL: begin
          if (deliver) begin
            head_data_d = skid_data_q;
            head_err_d  = skid_err_q;
          end
        end
        default: ;
      endcase
    end
    in_ready_d  = (state_d != S_FULL);
    out_valid_d = (state_d != S_EMPTY);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = head_data_q;
  assign sel_err   = head_err_q;

endmodule

// File: tb/tb_muxn_pipe.sv
// Self-checking bench for muxn_pipe: an N=4 and an N=3 instance share one
// directed stimulus stream; each has its own expected-beat queue.
module tb_muxn_pipe;

  typedef struct {
    logic [31:0] y;
    logic        err;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] d4;
  logic [95:0]  d3;
  logic [1:0]   sel;
  logic         in_valid;
  logic         out_ready;
  logic         flush;

  logic         ir4, ov4, err4;
  logic [31:0]  y4;
  logic         ir3, ov3, err3;
  logic [31:0]  y3;

  int checks;
  int errors;
  beat_t q4[$];
  beat_t q3[$];

  assign d3 = d4[95:0];

  muxn_pipe #(.WIDTH(32), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .d(d4), .sel(sel), .in_valid(in_valid),
    .in_ready(ir4), .out_valid(ov4), .out_ready(out_ready), .flush(flush),
    .y(y4), .sel_err(err4)
  );

  muxn_pipe #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .d(d3), .sel(sel), .in_valid(in_valid),
    .in_ready(ir3), .out_valid(ov3), .out_ready(out_ready), .flush(flush),
    .y(y3), .sel_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t model(input logic [127:0] dd, input logic [1:0] s, input int n);
    beat_t b;
    b.err = $isunknown(s) || (int'(s) >= n);
    b.y   = b.err ? dd[31:0] : dd[int'(s)*32 +: 32];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Evaluate the handshakes that will resolve at the coming rising edge.
  task automatic sb_eval();
    beat_t e;
    if (!rst_n) return;
    if (flush) begin
      q4.delete();
      q3.delete();
      return;
    end
    if (ov4 && out_ready) begin
      if (q4.size() == 0) chk("sb4_underflow", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        chk("sb4_y", y4, e.y);
        chk("sb4_err", 32'(err4), 32'(e.err));
      end
    end
    if (ov3 && out_ready) begin
      if (q3.size() == 0) chk("sb3_underflow", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        chk("sb3_y", y3, e.y);
        chk("sb3_err", 32'(err3), 32'(e.err));
      end
    end
    if (in_valid && ir4) q4.push_back(model(d4, sel, 4));
    if (in_valid && ir3) q3.push_back(model({32'd0, d3}, sel, 3));
  endtask

  // One cycle: score at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    sb_eval();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] s_saved;
    beat_t      m;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    d4        = '0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_in_ready", 32'(ir4), 32'd1);
    chk("rst_y", y4, 32'd0);
    chk("rst_sel_err", 32'(err4), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_out_valid", 32'(ov4), 32'd0);
      chk("idle_in_ready", 32'(ir4), 32'd1);
      chk("idle_y", y4, 32'd0);
    end

    // Streaming, full throughput
    d4 = {32'h33, 32'h22, 32'h11, 32'h00};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      sel = 2'(i);
      chk("stream_in_ready", 32'(ir4), 32'd1);
      tick();
      chk("stream_out_valid", 32'(ov4), 32'd1);
      chk("stream_y", y4, 32'h11 * 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(ov4), 32'd0);

    // Backpressure into FULL, then drain
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 2'd1;
    tick();
    sel = 2'd2;
    tick();
    chk("bp_in_ready", 32'(ir4), 32'd0);
    chk("bp_out_valid", 32'(ov4), 32'd1);
    chk("bp_y_head", y4, 32'h11);
    sel = 2'd3;
    tick();
    chk("bp_full_no_accept_y", y4, 32'h11);
    in_valid = 1'b0;
    tick();
    chk("bp_y_stable", y4, 32'h11);
    chk("bp_still_full", 32'(ir4), 32'd0);
    out_ready = 1'b1;
    chk("bp_y_d1", y4, 32'h11);
    tick();
    chk("bp_y_d2", y4, 32'h22);
    chk("bp_in_ready_back", 32'(ir4), 32'd1);
    tick();
    chk("bp_empty", 32'(ov4), 32'd0);

    // Bad selects (N=3 instance) with distinguishable channel 0
    d4 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h5A5A_5A5A};
    in_valid = 1'b1;
    sel = 2'd3;
    tick();
    chk("bad3_y", y3, 32'h5A5A_5A5A);
    chk("bad3_err", 32'(err3), 32'd1);
    chk("bad3_n4_y", y4, 32'h3333_3333);
    chk("bad3_n4_err", 32'(err4), 32'd0);
    sel = 2'bx;
    s_saved = sel;
    tick();
    m = model({32'd0, d3}, s_saved, 3);
    chk("badx_y", y3, m.y);
    chk("badx_err", 32'(err3), 32'(m.err));
    sel = 2'd2;
    tick();
    chk("good2_y", y3, 32'h2222_2222);
    chk("good2_err", 32'(err3), 32'd0);
    in_valid = 1'b0;
    tick();

    // Flush overrides accept and deliver in FULL
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 2'd1;
    tick();
    sel = 2'd2;
    tick();
    chk("fl_full", 32'(ir4), 32'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    sel = 2'd3;
    tick();
    chk("fl_out_valid", 32'(ov4), 32'd0);
    chk("fl_in_ready", 32'(ir4), 32'd1);
    chk("fl3_out_valid", 32'(ov3), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_ghost", 32'(ov4), 32'd0);
    end

    // Asynchronous reset pulse while FULL
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 2'd1;
    tick();
    sel = 2'd2;
    tick();
    in_valid = 1'b0;
    chk("ar_full", 32'(ir4), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(ov4), 32'd0);
    chk("ar_in_ready", 32'(ir4), 32'd1);
    chk("ar_y", y4, 32'd0);
    chk("ar3_out_valid", 32'(ov3), 32'd0);
    q4.delete();
    q3.delete();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Beat offered right after release is accepted
    in_valid = 1'b1;
    out_ready = 1'b1;
    sel = 2'd2;
    tick();
    chk("post_rst_valid", 32'(ov4), 32'd1);
    chk("post_rst_y", y4, 32'h2222_2222);
    in_valid = 1'b0;
    tick();
    tick();
    chk("sb4_empty", 32'(q4.size()), 32'd0);
    chk("sb3_empty", 32'(q3.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
